// File: rtl/dcache_axi_bridge_if.sv
// AXI4 channel bundle between the dcache miss-path bridge (master) and the interconnect (slave).
interface dcache_axi_bridge_if;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arid;
  logic        arvalid;
  logic        arready;

  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [3:0]  awid;
  logic        awvalid;
  logic        awready;

  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arlen, arsize, arburst, arid, arvalid, input arready,
    input  rdata, rresp, rlast, rvalid, output rready,
    output awaddr, awlen, awsize, awburst, awid, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bresp, bvalid, output bready
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arid, arvalid, output arready,
    output rdata, rresp, rlast, rvalid, input rready,
    input  awaddr, awlen, awsize, awburst, awid, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bresp, bvalid, input bready
  );
endinterface

// File: rtl/dcache_axi_bridge.sv
// Dcache miss-path AXI master: line fills, dirty write-backs and uncached single-word accesses.
module dcache_axi_bridge #(
  parameter logic [3:0]  AXI_ID     = 4'd1,
  parameter int unsigned LINE_WORDS = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ca_rreq_i,
  input  logic                       ca_wreq_i,
  input  logic                       uc_rreq_i,
  input  logic                       uc_wreq_i,
  input  logic [31:0]                addr_i,
  input  logic [3:0]                 wen_i,
  input  logic [31:0]                wdata_i,
  input  logic [LINE_WORDS*32-1:0]   line_wdata_i,
  output logic                       rend_o,
  output logic                       wend_o,
  output logic [LINE_WORDS*32-1:0]   line_rdata_o,
  output logic                       busy_o,
  dcache_axi_bridge_if.master        axi
);

  localparam int unsigned CW = $clog2(LINE_WORDS);
  localparam int unsigned OW = CW + 2;

  typedef enum logic [2:0] {
    S_IDLE, S_AR, S_R, S_DONE_R, S_AW, S_W, S_B, S_DONE_W
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     addr_q;
  logic [3:0]      wen_q;
  logic [31:0]     wdata_q;
  logic [31:0]     line_w_q [LINE_WORDS];
  logic [31:0]     line_r_q [LINE_WORDS];
  logic            uc_q;
  logic [CW-1:0]   cnt_q;
  logic            accept, acc_uc, acc_rd;
  logic [CW-1:0]   rslot;

  // Priority uc_r > uc_w > ca_r > ca_w folds into two select bits.
  always_comb begin
    accept = (state_q == S_IDLE) & (ca_rreq_i | ca_wreq_i | uc_rreq_i | uc_wreq_i);
    acc_uc = uc_rreq_i | uc_wreq_i;
    acc_rd = uc_rreq_i | (~uc_wreq_i & ca_rreq_i);
    rslot  = uc_q ? addr_q[OW-1:2] : cnt_q;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (accept) state_d = acc_rd ? S_AR : S_AW;
      S_AR:     if (axi.arready) state_d = S_R;
      S_R:      if (axi.rvalid && axi.rlast) state_d = S_DONE_R;
      S_DONE_R: state_d = S_IDLE;
      S_AW:     if (axi.awready) state_d = S_W;
      S_W:      if (axi.wready && axi.wlast) state_d = S_B;
      S_B:      if (axi.bvalid) state_d = S_DONE_W;
      S_DONE_W: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    axi.araddr  = uc_q ? addr_q : {addr_q[31:OW], {OW{1'b0}}};
    axi.arlen   = uc_q ? '0 : 8'(LINE_WORDS - 1);
    axi.arsize  = 3'd2;
    axi.arburst = 2'b01;
    axi.arid    = AXI_ID;
    axi.arvalid = (state_q == S_AR);
    axi.rready  = (state_q == S_R);
    axi.awaddr  = uc_q ? addr_q : {addr_q[31:OW], {OW{1'b0}}};
    axi.awlen   = uc_q ? '0 : 8'(LINE_WORDS - 1);
    axi.awsize  = 3'd2;
    axi.awburst = 2'b01;
    axi.awid    = AXI_ID;
    axi.awvalid = (state_q == S_AW);
    axi.wdata   = uc_q ? wdata_q : line_w_q[cnt_q];
    axi.wstrb   = uc_q ? wen_q : 4'hF;
    axi.wlast   = uc_q | (cnt_q == CW'(LINE_WORDS - 1));
    axi.wvalid  = (state_q == S_W);
    axi.bready  = (state_q == S_B);
    rend_o      = (state_q == S_DONE_R);
    wend_o      = (state_q == S_DONE_W);
    busy_o      = (state_q != S_IDLE);
  end

  always_comb begin
    line_rdata_o = '0;
    for (int unsigned k = 0; k < LINE_WORDS; k++) line_rdata_o[32*k +: 32] = line_r_q[k];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wen_q    <= '0;
      wdata_q  <= '0;
      uc_q     <= 1'b0;
      cnt_q    <= '0;
      line_w_q <= '{default: '0};
      line_r_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= addr_i;
        wen_q   <= wen_i;
        wdata_q <= wdata_i;
        uc_q    <= acc_uc;
        cnt_q   <= '0;
        for (int unsigned k = 0; k < LINE_WORDS; k++) line_w_q[k] <= line_wdata_i[32*k +: 32];
      end
      if (state_q == S_R && axi.rvalid) begin
        line_r_q[rslot] <= axi.rdata;
        cnt_q           <= cnt_q + CW'(1);
      end
      if (state_q == S_W && axi.wready) cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: tb/tb_dcache_axi_bridge.sv
// Bench for dcache_axi_bridge: AXI slave responder plus a transaction-level model checked every cycle.
module tb_dcache_axi_bridge;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, ca_rreq, ca_wreq, uc_rreq, uc_wreq;
  logic [31:0]  addr, wdata;
  logic [3:0]   wen;
  logic [255:0] line_wdata, line_rdata;
  logic         rend, wend, busy;

  dcache_axi_bridge_if axi();

  dcache_axi_bridge #(.AXI_ID(4'd1), .LINE_WORDS(8)) dut (
    .clk(clk), .rst(rst), .ca_rreq_i(ca_rreq), .ca_wreq_i(ca_wreq),
    .uc_rreq_i(uc_rreq), .uc_wreq_i(uc_wreq), .addr_i(addr), .wen_i(wen),
    .wdata_i(wdata), .line_wdata_i(line_wdata), .rend_o(rend), .wend_o(wend),
    .line_rdata_o(line_rdata), .busy_o(busy), .axi(axi)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%b want=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk256(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model and slave state
  bit          armed = 0, txn = 0, m_rd = 0, m_uc = 0;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wen;
  logic [31:0] m_lw [8];
  logic [31:0] exp_line [8];
  bit          ar_pend = 0, r_act = 0, aw_pend = 0, w_pend = 0, b_pend = 0;
  bit          exp_rend = 0, exp_wend = 0, done_now, phase = 0;
  int          rbeat = 0, rlastidx = 0, wbeat = 0, aw_wait = 0;

  // Knobs and observations used by directed tests
  logic [31:0] rd_words [8];
  int          early_last = -1, aw_delay = 0, aw_stalls = 0, wbeats_seen = 0;
  bit          w_toggle = 0;
  logic [1:0]  resp_err = 2'b00;
  logic [31:0] seen_araddr, seen_awaddr;
  logic [7:0]  seen_arlen, seen_awlen;
  logic [3:0]  seen_wstrb;

  function automatic logic [255:0] pack8(input logic [31:0] w [8]);
    logic [255:0] v = '0;
    for (int k = 0; k < 8; k++) v[32*k +: 32] = w[k];
    return v;
  endfunction

  always @(negedge clk) begin
    if (armed) begin
      chk256("line_rdata", line_rdata, pack8(exp_line));
      chk1("rend", rend, exp_rend);
      chk1("wend", wend, exp_wend);
      chk1("busy", busy, txn);
      chk1("arvalid", axi.arvalid, ar_pend);
      chk1("rready", axi.rready, r_act);
      chk1("awvalid", axi.awvalid, aw_pend);
      chk1("wvalid", axi.wvalid, w_pend);
      chk1("bready", axi.bready, b_pend);
      if (ar_pend) begin
        chk32("araddr", axi.araddr, m_uc ? m_addr : {m_addr[31:5], 5'b0});
        chk32("arlen", 32'(axi.arlen), m_uc ? 32'd0 : 32'd7);
        chk32("arsize", 32'(axi.arsize), 32'd2);
        chk32("arburst", 32'(axi.arburst), 32'd1);
        chk32("arid", 32'(axi.arid), 32'd1);
        seen_araddr = axi.araddr;
        seen_arlen  = axi.arlen;
      end
      if (aw_pend) begin
        chk32("awaddr", axi.awaddr, m_uc ? m_addr : {m_addr[31:5], 5'b0});
        chk32("awlen", 32'(axi.awlen), m_uc ? 32'd0 : 32'd7);
        chk32("awsize", 32'(axi.awsize), 32'd2);
        chk32("awburst", 32'(axi.awburst), 32'd1);
        chk32("awid", 32'(axi.awid), 32'd1);
        seen_awaddr = axi.awaddr;
        seen_awlen  = axi.awlen;
      end
      if (w_pend) begin
        chk32("wdata", axi.wdata, m_uc ? m_wdata : m_lw[wbeat]);
        chk32("wstrb", 32'(axi.wstrb), m_uc ? 32'(m_wen) : 32'hF);
        chk1("wlast", axi.wlast, m_uc || wbeat == 7);
      end
    end

    // Slave drives for the coming rising edge
    axi.arready = 1'b1;
    axi.rvalid  = r_act;
    axi.rdata   = rd_words[rbeat[2:0]];
    axi.rlast   = r_act && (rbeat == rlastidx);
    axi.rresp   = resp_err;
    axi.awready = axi.awvalid && (aw_wait >= aw_delay);
    phase       = ~phase;
    axi.wready  = w_pend && (!w_toggle || phase);
    axi.bvalid  = b_pend;
    axi.bresp   = resp_err;

    // Handshakes that will complete at that edge
    if (rst) begin
      armed = 1; txn = 0; ar_pend = 0; r_act = 0; aw_pend = 0; w_pend = 0; b_pend = 0;
      exp_rend = 0; exp_wend = 0; rbeat = 0; wbeat = 0; aw_wait = 0;
      for (int k = 0; k < 8; k++) exp_line[k] = '0;
    end else begin
      done_now = exp_rend | exp_wend;
      exp_rend = 0;
      exp_wend = 0;
      if (axi.rvalid && axi.rready) begin
        exp_line[m_uc ? int'(m_addr[4:2]) : rbeat] = axi.rdata;
        if (axi.rlast) begin r_act = 0; exp_rend = 1; end
        else rbeat++;
      end
      if (axi.arvalid && axi.arready) begin
        ar_pend = 0; r_act = 1; rbeat = 0;
        rlastidx = (early_last >= 0) ? early_last : int'(axi.arlen);
      end
      if (axi.bvalid && axi.bready) begin b_pend = 0; exp_wend = 1; end
      if (axi.wvalid && axi.wready) begin
        seen_wstrb = axi.wstrb;
        wbeats_seen++;
        if (m_uc || wbeat == 7) begin w_pend = 0; b_pend = 1; end
        else wbeat++;
      end
      if (axi.awvalid && axi.awready) begin
        aw_pend = 0; w_pend = 1; wbeat = 0; aw_wait = 0;
      end else if (axi.awvalid) begin
        aw_wait++; aw_stalls++;
      end
      if (!txn && (uc_rreq || uc_wreq || ca_rreq || ca_wreq)) begin
        txn  = 1;
        m_uc = uc_rreq || uc_wreq;
        m_rd = uc_rreq || (!uc_wreq && ca_rreq);
        m_addr = addr; m_wen = wen; m_wdata = wdata;
        for (int k = 0; k < 8; k++) m_lw[k] = line_wdata[32*k +: 32];
        if (m_rd) ar_pend = 1; else aw_pend = 1;
      end
      if (done_now) txn = 0;
    end
  end

  task automatic issue(input bit cr, cw, ur, uw, input logic [31:0] a, input logic [3:0] we,
                       input logic [31:0] wd, input logic [255:0] lw);
    @(posedge clk); #1;
    ca_rreq = cr; ca_wreq = cw; uc_rreq = ur; uc_wreq = uw;
    addr = a; wen = we; wdata = wd; line_wdata = lw;
    @(posedge clk); #1;
    ca_rreq = 0; ca_wreq = 0; uc_rreq = 0; uc_wreq = 0;
    addr = ~a; wen = ~we; wdata = ~wd; line_wdata = ~lw;
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rend === 1'b1 || wend === 1'b1) return;
    end
    checks++; errors++;
    $display("FAIL %s timeout got=none want=end pulse", nm);
  endtask

  function automatic logic [255:0] seq_line(input logic [31:0] base);
    logic [255:0] v = '0;
    for (int k = 0; k < 8; k++) v[32*k +: 32] = base + 32'(k);
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1);
  end

  initial begin
    int lowc;
    rst = 1; ca_rreq = 0; ca_wreq = 0; uc_rreq = 0; uc_wreq = 0;
    addr = '0; wen = '0; wdata = '0; line_wdata = '0;
    for (int k = 0; k < 8; k++) rd_words[k] = 32'h11 * 32'(k + 1);
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk); #1;
    chk1("reset_busy", busy, 1'b0);
    chk256("reset_line", line_rdata, 256'd0);

    // 1: cached fill, a stray request while busy is dropped
    issue(1, 0, 0, 0, 32'h1FC0_0044, 4'h0, 32'h0, '0);
    repeat (3) @(posedge clk);
    #1 uc_wreq = 1;
    @(posedge clk); #1 uc_wreq = 0;
    wait_done("t1");
    chk32("t1_araddr", seen_araddr, 32'h1FC0_0040);
    chk32("t1_arlen", 32'(seen_arlen), 32'd7);
    chk32("t1_word0", line_rdata[31:0], 32'h11);
    chk32("t1_word7", line_rdata[255:224], 32'h88);

    // 2: uncached read wins over a simultaneous cached write; error resp ignored
    rd_words[0] = 32'hDEAD_BEEF;
    resp_err = 2'b10;
    issue(0, 1, 1, 0, 32'hBFAF_8008, 4'h0, 32'h0, seq_line(32'h5000));
    wait_done("t2");
    chk32("t2_arlen", 32'(seen_arlen), 32'd0);
    chk32("t2_word2", line_rdata[95:64], 32'hDEAD_BEEF);
    chk32("t2_word0", line_rdata[31:0], 32'h11);
    resp_err = 2'b00;

    // 3: dirty write-back with wready toggling
    w_toggle = 1; wbeats_seen = 0;
    issue(0, 1, 0, 0, 32'h0000_1220, 4'h0, 32'h0, seq_line(32'd1));
    wait_done("t3");
    chk32("t3_awaddr", seen_awaddr, 32'h0000_1220);
    chk32("t3_awlen", 32'(seen_awlen), 32'd7);
    chk32("t3_beats", 32'(wbeats_seen), 32'd8);
    w_toggle = 0;

    // 4: uncached write with awready held off for 5 cycles
    aw_delay = 5; aw_stalls = 0; wbeats_seen = 0;
    issue(0, 0, 0, 1, 32'hBFD0_F010, 4'b0011, 32'h1234_5678, '0);
    wait_done("t4");
    chk32("t4_aw_stalls", 32'(aw_stalls), 32'd5);
    chk32("t4_wstrb", 32'(seen_wstrb), 32'h3);
    chk32("t4_beats", 32'(wbeats_seen), 32'd1);
    aw_delay = 0;

    // 5: back-to-back write then read with a single idle cycle between
    issue(0, 1, 0, 0, 32'h2000_0040, 4'h0, 32'h0, seq_line(32'hC000));
    wait_done("t5w");
    lowc = 0;
    fork
      issue(1, 0, 0, 0, 32'h3000_0020, 4'h0, 32'h0, '0);
      repeat (4) begin @(negedge clk); if (busy === 1'b0) lowc++; end
    join
    wait_done("t5r");
    chk32("t5_idle_cycles", 32'(lowc), 32'd1);

    // early rlast after 4 beats: upper words keep the previous fill
    for (int k = 0; k < 8; k++) rd_words[k] = 32'hA0 + 32'(k);
    early_last = 3;
    issue(1, 0, 0, 0, 32'h0000_0040, 4'h0, 32'h0, '0);
    wait_done("t7");
    chk32("t7_word3", line_rdata[127:96], 32'hA3);
    chk32("t7_word4", line_rdata[159:128], 32'h55);
    early_last = -1;

    // 6: reset during read beat 3, then a clean fill
    for (int k = 0; k < 8; k++) rd_words[k] = 32'h11 * 32'(k + 1);
    issue(1, 0, 0, 0, 32'h0000_0100, 4'h0, 32'h0, '0);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (r_act && rbeat == 3) break;
    end
    #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk); #1;
    chk256("t6_line", line_rdata, 256'd0);
    chk1("t6_busy", busy, 1'b0);
    chk1("t6_rready", axi.rready, 1'b0);
    chk1("t6_arvalid", axi.arvalid, 1'b0);
    issue(1, 0, 0, 0, 32'h0000_0200, 4'h0, 32'h0, '0);
    wait_done("t6");
    chk32("t6_word0", line_rdata[31:0], 32'h11);
    chk32("t6_word7", line_rdata[255:224], 32'h88);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
